// File: rtl/nt_level_integrator.sv
`timescale 1ns/1ps
// nt_level_integrator
//
// Consumer end of the neurotransmitter regulator interface. It integrates
// the inc/dec/fast requests for one transmitter into a saturating internal
// level. The level is updated once per prescaled step. When no requests
// arrive for a while, the level relaxes back toward a baseline.
//
// Ports:
//   clk      system clock
//   rst      synchronous reset, active-high
//   en       step enable; when low, the prescaler and all state hold
//   inc      increase request (sampled only in the step-strobe cycle)
//   dec      decrease request (sampled only in the step-strobe cycle)
//   fast     selects STEP_FAST instead of STEP_SLOW
//   level    current internal level (registered)
//   level_q  quantised level, top two bits of level
//   sat_hi   level is at its maximum value
//   sat_lo   level is zero
//   updated  one-cycle pulse: level changed on the preceding edge
module nt_level_integrator #(
  parameter int WIDTH       = 8,
  parameter int PRESCALE    = 256,
  parameter int STEP_SLOW   = 1,
  parameter int STEP_FAST   = 4,
  parameter int BASELINE    = 128,
  parameter int DECAY_STEPS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             inc,
  input  logic             dec,
  input  logic             fast,
  output logic [WIDTH-1:0] level,
  output logic [1:0]       level_q,
  output logic             sat_hi,
  output logic             sat_lo,
  output logic             updated
);

  localparam int CNT_W  = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  // The idle counter holds 0..DECAY_STEPS, so an increment never overflows.
  localparam int IDLE_W = (DECAY_STEPS > 1) ? $clog2(DECAY_STEPS + 1) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(PRESCALE - 1);
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(DECAY_STEPS);
  localparam logic [WIDTH-1:0]  BASE_V     = WIDTH'(BASELINE);
  localparam logic [WIDTH:0]    LEVEL_MAX  = {1'b0, {WIDTH{1'b1}}};

  logic [CNT_W-1:0]  count;
  logic [IDLE_W-1:0] idle;
  logic [WIDTH-1:0]  level_r;

  logic              step;
  logic [WIDTH:0]    step_size;
  logic [WIDTH:0]    sum_ext;
  logic [WIDTH:0]    level_ext;
  logic [IDLE_W-1:0] idle_inc;
  logic [WIDTH-1:0]  level_nxt;
  logic [IDLE_W-1:0] idle_nxt;

  assign step      = en && (count == CNT_LAST);
  assign level_ext = {1'b0, level_r};
  assign step_size = fast ? (WIDTH+1)'(STEP_FAST) : (WIDTH+1)'(STEP_SLOW);
  assign sum_ext   = level_ext + step_size;
  assign idle_inc  = idle + IDLE_W'(1);

  // Value the level and idle counter take if this cycle is a step.
  // NOTE: every signal assigned here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    level_nxt = level_r;
    idle_nxt  = idle;
    if (inc && !dec) begin
      level_nxt = (sum_ext > LEVEL_MAX) ? {WIDTH{1'b1}} : sum_ext[WIDTH-1:0];
      idle_nxt  = '0;
    end else if (dec && !inc) begin
      // Floor at zero rather than wrapping when the step exceeds the level.
      level_nxt = (level_ext < step_size) ? '0
                                          : WIDTH'(level_ext - step_size);
      idle_nxt  = '0;
    end else if (idle_inc >= IDLE_LIMIT) begin
      // Enough quiet steps: nudge one count toward the baseline.
      if (level_r < BASE_V) begin
        level_nxt = level_r + WIDTH'(1);
      end else if (level_r > BASE_V) begin
        level_nxt = level_r - WIDTH'(1);
      end
      idle_nxt = '0;
    end else begin
      idle_nxt = idle_inc;
    end
  end

  // NOTE: state registers use non-blocking assignments so that every flop
  // samples the values from before the edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      idle    <= '0;
      level_r <= BASE_V;
      updated <= 1'b0;
    end else if (step) begin
      count   <= '0;
      idle    <= idle_nxt;
      level_r <= level_nxt;
      updated <= (level_nxt != level_r);
    end else begin
      if (en) begin
        count <= count + CNT_W'(1);
      end
      updated <= 1'b0;
    end
  end

  assign level   = level_r;
  assign level_q = level_r[WIDTH-1:WIDTH-2];
  assign sat_hi  = (level_r == {WIDTH{1'b1}});
  assign sat_lo  = (level_r == '0);

endmodule

// File: tb/tb_nt_level_integrator.sv
`timescale 1ns/1ps
// Testbench for nt_level_integrator. Three instances share one set of
// inputs. Each instance has PRESCALE=4, and they differ only in BASELINE
// and DECAY_STEPS:
//   inst 0: BASELINE=128, DECAY_STEPS=2
//   inst 1: BASELINE=6,   DECAY_STEPS=8
//   inst 2: BASELINE=253, DECAY_STEPS=8
// A behavioural model predicts every output each cycle. Directed literal
// checks pin the key values.
module tb_nt_level_integrator;

  localparam int PRE = 4;
  localparam int BASE_P [3] = '{128, 6, 253};
  localparam int DEC_P  [3] = '{2, 8, 8};

  logic clk = 1'b0;
  logic rst, en, inc, dec, fast;

  logic [2:0][7:0] dut_level;
  logic [2:0][1:0] dut_q;
  logic [2:0]      dut_hi, dut_lo, dut_upd;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  nt_level_integrator #(.WIDTH(8), .PRESCALE(PRE), .STEP_SLOW(1), .STEP_FAST(4),
                        .BASELINE(128), .DECAY_STEPS(2)) u0 (
    .clk(clk), .rst(rst), .en(en), .inc(inc), .dec(dec), .fast(fast),
    .level(dut_level[0]), .level_q(dut_q[0]), .sat_hi(dut_hi[0]),
    .sat_lo(dut_lo[0]), .updated(dut_upd[0]));

  nt_level_integrator #(.WIDTH(8), .PRESCALE(PRE), .STEP_SLOW(1), .STEP_FAST(4),
                        .BASELINE(6), .DECAY_STEPS(8)) u1 (
    .clk(clk), .rst(rst), .en(en), .inc(inc), .dec(dec), .fast(fast),
    .level(dut_level[1]), .level_q(dut_q[1]), .sat_hi(dut_hi[1]),
    .sat_lo(dut_lo[1]), .updated(dut_upd[1]));

  nt_level_integrator #(.WIDTH(8), .PRESCALE(PRE), .STEP_SLOW(1), .STEP_FAST(4),
                        .BASELINE(253), .DECAY_STEPS(8)) u2 (
    .clk(clk), .rst(rst), .en(en), .inc(inc), .dec(dec), .fast(fast),
    .level(dut_level[2]), .level_q(dut_q[2]), .sat_hi(dut_hi[2]),
    .sat_lo(dut_lo[2]), .updated(dut_upd[2]));

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a cycle counter per instance, plus integer level and
  // quiet-step bookkeeping.
  int  m_lvl [3];
  int  m_idle[3];
  int  m_ph  [3];
  bit  m_upd [3];
  bit  model_valid = 1'b0;
  int  s_m, nl_m;

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_lvl[i] = BASE_P[i]; m_idle[i] = 0; m_ph[i] = 0; m_upd[i] = 0;
      end else if (!en) begin
        m_upd[i] = 0;
      end else if (m_ph[i] != PRE - 1) begin
        m_ph[i]++;
        m_upd[i] = 0;
      end else begin
        m_ph[i] = 0;
        s_m = fast ? 4 : 1;
        nl_m = m_lvl[i];
        if (inc && !dec) begin
          nl_m = (m_lvl[i] + s_m > 255) ? 255 : m_lvl[i] + s_m;
          m_idle[i] = 0;
        end else if (dec && !inc) begin
          nl_m = (m_lvl[i] - s_m < 0) ? 0 : m_lvl[i] - s_m;
          m_idle[i] = 0;
        end else begin
          m_idle[i]++;
          if (m_idle[i] >= DEC_P[i]) begin
            m_idle[i] = 0;
            if (m_lvl[i] < BASE_P[i]) nl_m = m_lvl[i] + 1;
            else if (m_lvl[i] > BASE_P[i]) nl_m = m_lvl[i] - 1;
          end
        end
        m_upd[i] = (nl_m != m_lvl[i]);
        m_lvl[i] = nl_m;
      end
    end
    if (rst) model_valid = 1'b1;
  end

  // Compare process: on every falling edge, check all outputs of every
  // instance against the model.
  always @(negedge clk) begin
    if (model_valid) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("model_level[%0d]", i), dut_level[i], m_lvl[i]);
        check($sformatf("model_level_q[%0d]", i), dut_q[i], m_lvl[i] >> 6);
        check($sformatf("model_sat_hi[%0d]", i), dut_hi[i], (m_lvl[i] == 255) ? 1 : 0);
        check($sformatf("model_sat_lo[%0d]", i), dut_lo[i], (m_lvl[i] == 0) ? 1 : 0);
        check($sformatf("model_updated[%0d]", i), dut_upd[i], m_upd[i] ? 1 : 0);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b1; inc = 1'b0; dec = 1'b0; fast = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic run_step();
    repeat (PRE) cyc();
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; inc = 1'b0; dec = 1'b0; fast = 1'b0;
    do_reset();

    // Reset state.
    check("rst_level0", dut_level[0], 128);
    check("rst_q0", dut_q[0], 2);
    check("rst_hi0", dut_hi[0], 0);
    check("rst_lo0", dut_lo[0], 0);
    check("rst_upd0", dut_upd[0], 0);
    check("rst_level1", dut_level[1], 6);
    check("rst_level2", dut_level[2], 253);

    // Slow inc: inc toggles freely, but is 1 in every strobe cycle.
    for (int k = 1; k <= 12; k++) begin
      inc = ((k - 1) % 4 == 3) ? 1'b1 : 1'((k - 1) % 2);
      cyc();
      check($sformatf("inc_upd_k%0d", k), dut_upd[0], (k % 4 == 0) ? 1 : 0);
      if (k % 4 == 0) check($sformatf("inc_level_k%0d", k), dut_level[0], 128 + k / 4);
    end
    inc = 1'b0;

    // Fast dec with floor, on the BASELINE=6 instance.
    do_reset();
    fast = 1'b1; dec = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      if (k == 4) begin
        check("fdec_level_s1", dut_level[1], 2);
        check("fdec_upd_s1", dut_upd[1], 1);
      end
      if (k == 8) begin
        check("fdec_level_s2", dut_level[1], 0);
        check("fdec_satlo_s2", dut_lo[1], 1);
        check("fdec_upd_s2", dut_upd[1], 1);
      end
      if (k == 12) begin
        check("fdec_level_s3", dut_level[1], 0);
        check("fdec_upd_s3", dut_upd[1], 0);
      end
    end
    fast = 1'b0; dec = 1'b0;

    // Saturation high, on the BASELINE=253 instance.
    do_reset();
    inc = 1'b1; fast = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      if (k == 4) begin
        check("sat_level_s1", dut_level[2], 255);
        check("sat_hi_s1", dut_hi[2], 1);
        check("sat_q_s1", dut_q[2], 3);
        check("sat_upd_s1", dut_upd[2], 1);
      end
      if (k == 8) begin
        check("sat_level_s2", dut_level[2], 255);
        check("sat_upd_s2", dut_upd[2], 0);
      end
    end
    inc = 1'b0; fast = 1'b0;

    // Decay on inst 0 (DECAY_STEPS=2).
    do_reset();
    inc = 1'b1;
    repeat (12) cyc();
    check("decay_pre", dut_level[0], 131);
    inc = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      cyc();
      if (k == 4) check("decay_s1_hold", dut_level[0], 131);
      if (k % 8 == 0) check($sformatf("decay_s%0d", k / 4), dut_level[0], 131 - k / 8);
    end
    inc = 1'b1; run_step(); check("restart_inc1", dut_level[0], 129);
    inc = 1'b0; run_step(); check("restart_idle1", dut_level[0], 129);
    inc = 1'b1; run_step(); check("restart_inc2", dut_level[0], 130);
    inc = 1'b0; run_step(); check("restart_idle2", dut_level[0], 130);
    inc = 1'b1; dec = 1'b1; run_step();
    check("both_is_idle_level", dut_level[0], 129);
    check("both_is_idle_upd", dut_upd[0], 1);
    inc = 1'b0; dec = 1'b0;

    // en low holds the counter phase and the level.
    inc = 1'b1;
    cyc(); cyc();
    en = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      check($sformatf("en_hold_level_k%0d", k), dut_level[0], 129);
      check($sformatf("en_hold_upd_k%0d", k), dut_upd[0], 0);
    end
    en = 1'b1;
    cyc();
    check("en_resume_pre", dut_level[0], 129);
    cyc();
    check("en_resume_level", dut_level[0], 130);
    check("en_resume_upd", dut_upd[0], 1);

    // Reset asserted in a strobe cycle with inc=1.
    cyc(); cyc(); cyc();
    rst = 1'b1;
    cyc();
    check("rst_strobe_level", dut_level[0], 128);
    check("rst_strobe_upd", dut_upd[0], 0);
    rst = 1'b0; inc = 1'b0;
    repeat (4) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nt_level_integrator.md
Name: nt_level_integrator

Overview:
- Consumer end of the neurotransmitter regulator interface: integrates the per-transmitter inc/dec/fast requests into a saturating internal level.
- Publishes the 2-bit quantised level that feeds the neurotransmitter_level bus (e.g. GABA = bits [5:4]).
- Includes a step prescaler and homeostatic decay toward a baseline.
- One instance per transmitter (CORT, DOP, GABA, NE, SER).

Parameters:
- WIDTH, 8, bit width of the internal level.
- PRESCALE, 256, clock cycles per integration step; must be ≥2.
- STEP_SLOW, 1, level change per step when fast=0.
- STEP_FAST, 4, level change per step when fast=1.
- BASELINE, 128, reset value and decay target.
- DECAY_STEPS, 8, consecutive request-free steps before one decay move.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- en  input  1  step enable; when low, prescaler and all state hold.
- inc  input  1  increase request from the regulator.
- dec  input  1  decrease request from the regulator.
- fast  input  1  selects STEP_FAST instead of STEP_SLOW.
- level  output  WIDTH  current internal level, registered.
- level_q  output  2  quantised level = level[WIDTH-1:WIDTH-2].
- sat_hi  output  1  level == 2^WIDTH-1.
- sat_lo  output  1  level == 0.
- updated  output  1  one-cycle pulse; level changed on the preceding edge.

Behaviour:
- Reset (rst=1 at a clk edge) overrides everything, including mid-step:
  - level=BASELINE, prescaler=0, idle counter=0, updated=0.
  - sat_hi and sat_lo take their values from BASELINE (both 0 for the default).
- Prescaler:
  - When en=1, the counter increments 0..PRESCALE-1 and then wraps to 0.
  - step strobe = en && (counter == PRESCALE-1).
  - When en=0, the counter, level and idle counter all hold, and updated=0.
- Sampling:
  - inc/dec/fast are sampled only in the step-strobe cycle; values in other cycles are ignored.
  - The new level is visible one cycle after the strobe edge, i.e. level is registered at the strobe edge.
- Request decode at step:
  - inc=1, dec=0: level += S.
  - dec=1, inc=0: level -= S.
  - inc=dec=1: treated as no request.
  - inc=dec=0: no request.
  - S = STEP_FAST if fast else STEP_SLOW. fast with no request has no effect.
- Arithmetic:
  - Computed in WIDTH+1 bits.
  - Increase saturates at 2^WIDTH-1.
  - Decrease saturates at 0 (if level < S, result 0).
  - No wrap-around.
- Idle/decay:
  - A step with a valid inc or dec clears the idle counter.
  - A no-request step increments the idle counter.
  - When the idle counter reaches DECAY_STEPS on a no-request step, level moves 1 toward BASELINE and the idle counter clears.
  - If level == BASELINE, there is no move, but the counter still clears.
  - The idle counter is sized to hold DECAY_STEPS and never overflows.
- updated:
  - Registered; high for exactly one cycle after any strobe edge where the level value actually changed.
  - Low when saturation blocked the change, and low when decay found level == BASELINE.
- Outputs:
  - sat_hi, sat_lo and level_q are combinational from the level register.
  - They therefore track level with zero extra latency.

Test Plan:
- Reset/idle: PRESCALE=4, rst 2 cycles, en=1, no requests.
  - Required: level=128, level_q=2'b10, sat_hi=sat_lo=0, updated=0.
- Slow inc: inc=1 held for 3 steps (12 cycles).
  - Required: level 129, 130, 131.
  - updated pulses once per step, on cycles 4, 8, 12 after reset release.
  - Toggling inc in non-strobe cycles has no effect.
- Fast dec with floor: preload by reset with BASELINE=6, fast=1, dec=1 for 3 steps.
  - Required: level 2, then 0, then 0.
  - sat_lo=1 after the second step.
  - updated pulses after the first two steps only.
- Saturation high: BASELINE=253, STEP_FAST=4, inc+fast for 2 steps.
  - Required: level=255, sat_hi=1, level_q=2'b11.
  - Second step gives no updated pulse.
- Decay: DECAY_STEPS=2, drive level to 131, then no requests for 6 steps.
  - Required: level 130 after step 2, 129 after step 4, 128 after step 6.
  - A single inc step inserted mid-sequence restarts the idle count.
  - inc=dec=1 counts as idle.
- en/reset mid-operation:
  - en=0 for 10 cycles holds the counter and level; the strobe resumes at the same phase.
  - rst asserted in a strobe cycle with inc=1 leaves level=BASELINE and updated=0 on the next cycle.
